seg7_scan_display: RTL and testbench

- Parametrised, time-multiplexed seven-segment driver for the CPU top.
- Selects one of CH 32-bit debug channels (LED data, PC, cycle count, ...) via switches.
- Latches the selected value once per refresh frame, so the display never shows a mix of old and new digits.
- Scans DIGITS common-anode digits in hex, with optional leading-zero blanking and a freeze mode.

---
 rtl/seg7_scan_display.sv | 151 +++++++++++++++
 tb/tb_seg7_scan_display.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_display
//  Description : Time-multiplexed hex seven-segment driver with channel select,
//                per-frame value latching, leading-zero blanking and freeze.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_display #(
    parameter int DIGITS   = 8,
    parameter int CH       = 4,
    parameter int SEL_W    = 2,
    parameter int SCAN_DIV = 100000,
    parameter int DIV_W    = 17
) (
    input  logic                clk,
    input  logic                CPU_RESETN,
    input  logic [SEL_W-1:0]    sel,
    input  logic [CH*32-1:0]    ch_data,
    input  logic                freeze,
    input  logic                blank_lz,
    output logic [DIGITS-1:0]   an,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [31:0]         disp_value
);

    localparam int               c_NSEL     = 1 << SEL_W;
    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [2:0]       c_IDX_LAST = 3'(DIGITS - 1);

    logic [DIV_W-1:0]  r_div_cnt;
    logic [2:0]        r_digit_idx;
    logic [DIGITS-1:0] r_an;
    logic [6:0]        r_seg;
    logic              r_dp;
    logic [31:0]       r_disp_value;
    logic              r_load_pending;

    logic [31:0]       w_ch [c_NSEL];
    logic [c_NSEL-1:0] w_ch_valid;
    logic [31:0]       w_sel_data;
    logic              w_oor;
    logic              w_tick;
    logic              w_frame_end;
    logic              w_load;
    logic [2:0]        w_msd;
    logic              w_blank;
    logic [3:0]        w_nib;
    logic [6:0]        w_seg_on;
    logic [DIGITS-1:0] w_an_next;
    logic              w_dp_next;

    // Select slots beyond CH read as zero and are flagged out of range.
    genvar gi;
    generate
        for (gi = 0; gi < c_NSEL; gi++) begin : g_ch
            if (gi < CH) begin : g_used
                assign w_ch[gi]       = ch_data[32*gi +: 32];
                assign w_ch_valid[gi] = 1'b1;
            end else begin : g_unused
                assign w_ch[gi]       = 32'h0000_0000;
                assign w_ch_valid[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_sel_data  = w_ch[sel];
    assign w_oor       = ~w_ch_valid[sel];

    assign w_tick      = (r_div_cnt == c_DIV_LAST);
    assign w_frame_end = w_tick && (r_digit_idx == c_IDX_LAST);
    assign w_load      = (w_frame_end || r_load_pending) && !freeze;

    // Highest non-zero nibble among the displayed digits only.
    always_comb begin
        w_msd = 3'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_disp_value[4*k +: 4] != 4'h0) begin
                w_msd = 3'(k);
            end
        end
    end

    assign w_blank = blank_lz && (r_digit_idx > w_msd);
    assign w_nib   = r_disp_value[{r_digit_idx, 2'b00} +: 4];

    always_comb begin
        w_an_next = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if ((r_digit_idx == 3'(k)) && !w_blank) begin
                w_an_next[k] = 1'b0;
            end
        end
    end

    always_comb begin
        case (w_nib)
            4'h0:    w_seg_on = 7'h3F;
            4'h1:    w_seg_on = 7'h06;
            4'h2:    w_seg_on = 7'h5B;
            4'h3:    w_seg_on = 7'h4F;
            4'h4:    w_seg_on = 7'h66;
            4'h5:    w_seg_on = 7'h6D;
            4'h6:    w_seg_on = 7'h7D;
            4'h7:    w_seg_on = 7'h07;
            4'h8:    w_seg_on = 7'h7F;
            4'h9:    w_seg_on = 7'h6F;
            4'hA:    w_seg_on = 7'h77;
            4'hB:    w_seg_on = 7'h7C;
            4'hC:    w_seg_on = 7'h39;
            4'hD:    w_seg_on = 7'h5E;
            4'hE:    w_seg_on = 7'h79;
            default: w_seg_on = 7'h71;
        endcase
    end

    assign w_dp_next = !((freeze && (r_digit_idx == 3'd0)) || w_oor);

    // Outputs register the digit being left on each tick, so a reload at
    // frame end never mixes into the frame currently being shown.
    always_ff @(posedge clk) begin
        if (!CPU_RESETN) begin
            r_div_cnt      <= '0;
            r_digit_idx    <= 3'd0;
            r_an           <= '1;
            r_seg          <= 7'h7F;
            r_dp           <= 1'b1;
            r_disp_value   <= 32'h0000_0000;
            r_load_pending <= 1'b1;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            if (w_tick) begin
                r_digit_idx <= (r_digit_idx == c_IDX_LAST) ? 3'd0 : r_digit_idx + 3'd1;
                r_an        <= w_an_next;
                r_seg       <= ~w_seg_on;
                r_dp        <= w_dp_next;
            end
            if (w_load) begin
                r_disp_value   <= w_sel_data;
                r_load_pending <= 1'b0;
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign disp_value = r_disp_value;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_display
//  Description : Scoreboard bench for seg7_scan_display (8 digits, 3 channels).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_display;

    localparam int DIGITS   = 8;
    localparam int CH       = 3;
    localparam int SEL_W    = 2;
    localparam int SCAN_DIV = 4;
    localparam int DIV_W    = 3;
    localparam int R0       = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  sel;
    logic [95:0] ch_data;
    logic        freeze;
    logic        blank_lz;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [31:0] disp_value;

    seg7_scan_display #(
        .DIGITS   (DIGITS),
        .CH       (CH),
        .SEL_W    (SEL_W),
        .SCAN_DIV (SCAN_DIV),
        .DIV_W    (DIV_W)
    ) dut (
        .clk        (clk),
        .CPU_RESETN (rstn),
        .sel        (sel),
        .ch_data    (ch_data),
        .freeze     (freeze),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .disp_value (disp_value)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [7:0]  an;
        logic [6:0]  seg;
        bit          seg_care;
        logic        dp;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [31:0] frame_val(input int f);
        case (f)
            0, 1:       return 32'h1234_ABCD;
            2, 3:       return 32'h0000_00FF;
            8:          return 32'h5555_5555;
            default:    return 32'h0000_0000;
        endcase
    endfunction

    task automatic push(input int c, input logic [7:0] a, input logic [6:0] s,
                        input bit sc, input logic d, input logic [31:0] v);
        exp_t e;
        e.cyc = c; e.an = a; e.seg = s; e.seg_care = sc; e.dp = d; e.val = v;
        q.push_back(e);
    endtask

    // One display slot of the main run: flags follow the stimulus timeline.
    task automatic push_slot(input int s, input int extra);
        int          k;
        int          msd;
        logic [31:0] v;
        logic [7:0]  a;
        bit          blz, frz, oor, blank;
        k   = s % 8;
        v   = frame_val(s / 8);
        blz = (s >= 24);
        frz = (s >= 33) && (s <= 59);
        oor = (s >= 65);
        msd = 0;
        for (int i = 0; i < 8; i++) if (v[4*i +: 4] != 4'h0) msd = i;
        blank = blz && (k > msd);
        a = 8'hFF;
        if (!blank) a[k] = 1'b0;
        push(R0 + 3 + SCAN_DIV*s + extra, a, ~pat[v[4*k +: 4]], !blank,
             !((frz && k == 0) || oor), frame_val((s + 1) / 8));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed cyc=%0d got=%0d want=%0d", e.cyc, cyc, e.cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            chk("an", {24'h0, an}, {24'h0, e.an});
            if (e.seg_care) chk("seg", {25'h0, seg}, {25'h0, e.seg});
            chk("dp", {31'h0, dp}, {31'h0, e.dp});
            chk("disp_value", disp_value, e.val);
        end
    end

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn     = 1'b0;
        sel      = 2'd1;
        ch_data  = {32'h0000_00FF, 32'h1234_ABCD, 32'hDEAD_BEEF};
        freeze   = 1'b0;
        blank_lz = 1'b0;

        // Reset state, load one cycle after release, first frame with hold checks.
        push(1, 8'hFF, 7'h7F, 1'b1, 1'b1, 32'h0);
        push(3, 8'hFF, 7'h7F, 1'b1, 1'b1, 32'h0);
        push(4, 8'hFF, 7'h7F, 1'b1, 1'b1, 32'h1234_ABCD);
        push(7, 8'hFE, 7'h21, 1'b1, 1'b1, 32'h1234_ABCD);
        push_slot(0, 3);
        for (int s = 1; s < 8; s++) begin
            push_slot(s, 0);
            push_slot(s, 3);
        end
        push_slot(8, 0);
        push_slot(9, 0);
        goto(3);
        rstn = 1'b1;

        // Channel switch mid-frame at digit_idx 3.
        for (int s = 10; s < 24; s++) push_slot(s, 0);
        goto(48);
        sel = 2'd2;

        for (int s = 24; s < 32; s++) push_slot(s, 0);
        goto(100);
        blank_lz = 1'b1;
        goto(104);
        ch_data[95:64] = 32'h0000_0000;

        // Freeze over frames 5..7, release mid-frame 7.
        for (int s = 32; s < 64; s++) push_slot(s, 0);
        goto(136);
        freeze = 1'b1;
        ch_data[95:64] = 32'h5555_5555;
        goto(244);
        freeze = 1'b0;

        // Out-of-range select, then reset at digit_idx 5.
        for (int s = 64; s < 77; s++) push_slot(s, 0);
        push(313, 8'hFF, 7'h7F, 1'b1, 1'b1, 32'h0);
        push(314, 8'hFF, 7'h7F, 1'b1, 1'b1, 32'h1234_ABCD);
        push(317, 8'hFE, 7'h21, 1'b1, 1'b1, 32'h1234_ABCD);
        push(321, 8'hFD, 7'h46, 1'b1, 1'b1, 32'h1234_ABCD);
        goto(264);
        sel = 2'd3;
        goto(312);
        rstn = 1'b0;
        sel  = 2'd1;
        goto(313);
        rstn = 1'b1;

        goto(330);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover got=%0d want=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
